aes_block_initiator: RTL and testbench
======================================

Name: aes_block_initiator

Overview:
- AXI4-Lite initiator (master) that drives the AES accelerator's register slave from a 128-bit block stream.
- Each accepted input block is written as four 32-bit words to the accelerator's input FIFO register. It then reads four words back from the output FIFO register and presents the reassembled 128-bit result on an output stream.
- Sits between a local block producer/consumer and the accelerator's MMIO port, replacing CPU-driven polling.

Parameters:
- BASE_ADDR, 38'h0, accelerator base; the register offset is added in the low 16 bits.
- TIMEOUT_CYCLES, 1024, wait-cycle limit per handshake; used only with AXIL_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- wraddr_valid  out  1  write address valid
- wraddr_ready  in  1  write address ready
- wraddr  out  38  write address
- wr_valid  out  1  write data valid
- wr_ready  in  1  write data ready
- wr_dat  out  32  write data
- wrresp_valid  in  1  write response valid
- wrresp_ready  out  1  write response ready
- wrresp_dat  in  2  write response code
- rdaddr_valid  out  1  read address valid
- rdaddr_ready  in  1  read address ready
- rdaddr  out  38  read address
- rd_valid  in  1  read data valid
- rd_ready  out  1  read data ready
- rd_dat  in  32  read data
- rdresp_dat  in  2  read response code
- in_valid  in  1  input block valid
- in_ready  out  1  input block ready (high only in IDLE)
- in_block  in  128  plaintext/ciphertext block
- out_valid  out  1  result block valid
- out_ready  in  1  result block ready
- out_block  out  128  result block
- busy  out  1  high whenever state is not IDLE
- err  out  1  sticky: a non-OKAY response was seen (or a timeout, with the option)

Behaviour:
- Reset (rst=0): state IDLE, word counter 0, err 0, all *_valid/*_ready outputs 0, addresses/data/out_block 0.
- Exactly one outstanding transaction. Write data is driven only after the address handshake completes.
- Word order is big-endian: word 0 = block[127:96], word 3 = block[31:0]. Read word k fills the same slice.
- Write address = BASE_ADDR + 16'h0004. Read address = BASE_ADDR + 16'h0008.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_block, cnt=0, go to WADDR.
- WADDR:
  - wraddr_valid=1.
  - On handshake go to WDATA.
- WDATA:
  - wr_valid=1, wr_dat = latched word[cnt], held stable until wr_ready.
  - On handshake go to WRESP.
- WRESP:
  - wrresp_ready=1.
  - On handshake: if wrresp_dat!=0, set err.
  - If cnt==3: cnt=0, go to RADDR. Otherwise cnt++, go to WADDR.
- RADDR:
  - rdaddr_valid=1.
  - On handshake go to RDATA.
- RDATA:
  - rd_ready=1.
  - On handshake: store rd_dat into result word[cnt]; if rdresp_dat!=0, set err.
  - If cnt==3, go to OUT. Otherwise cnt++, go to RADDR.
- OUT:
  - out_valid=1, out_block stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 until then, so there is no overlap.
- Valid outputs, once raised, are not lowered before their handshake (except on reset or timeout).
- Latency with an always-ready slave: out_valid is first high 21 cycles after the in_valid/in_ready cycle.
- Error responses do not abort; the block still completes. err clears only on reset.
- Counter wrap: the 2-bit cnt wraps 3→0 only at the two phase boundaries above.
- Reset mid-transaction: all valids drop asynchronously. The partial block is discarded. The slave is expected to be soft-reset by software.

Optional Feature:
- Macro: AXIL_TIMEOUT_EN.
- Defined:
  - A wait counter runs in each of WADDR/WDATA/WRESP/RADDR/RDATA while its handshake is pending; it clears on every handshake.
  - On reaching TIMEOUT_CYCLES: set err, drop all valids, go to IDLE, discard the block.
- Undefined: no counter; waits are unbounded.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - register offsets (AES_CTL 16'h0000, FIFO_IN 16'h0004, FIFO_OUT 16'h0008, CTR 16'h0010, KEY 16'h0020);
  - response codes (OKAY 2'b00, SLVERR 2'b10).
- One natural sub-module, axil_single_xfer: a one-transaction engine (address/data/response sequencing plus timeout), driven by a word-level sequencer in aes_block_initiator.

Test Plan:
- Reset: hold rst=0 mid-operation → all valids 0, busy 0, err 0 immediately. After release, in_ready=1.
- Always-ready slave, in_block=128'h00112233_44556677_8899aabb_ccddeeff →
  - four writes to 38'h4 with data 00112233, 44556677, 8899aabb, ccddeeff;
  - four reads from 38'h8;
  - slave returning words A0..A3 yields out_block={A0,A1,A2,A3};
  - out_valid at cycle 21.
- Backpressure: wr_ready=0 for 5 cycles on word 2 → wr_valid stays 1 and wr_dat stays 8899aabb. Total latency becomes 26.
- rdresp_dat=2'b10 on read word 3 → err=1 and stays 1. The block is still delivered; the next block runs normally with err still 1.
- out_ready=0 for 10 cycles → out_block stable, in_ready=0, no AXI activity. Consumption occurs on the cycle out_ready=1.
- With AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=16, wrresp_valid never asserts → after 16 wait cycles err=1, valids 0, in_ready=1.

Source files
------------

// File: rtl/aes_block_initiator_pkg.sv
// Shared constants, state encodings and helpers for the AES block initiator.
package aes_block_initiator_pkg;

    localparam int unsigned ADDR_W = 38;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned OFF_W  = 16;

    localparam logic [OFF_W-1:0] REG_AES_CTL  = 16'h0000;
    localparam logic [OFF_W-1:0] REG_FIFO_IN  = 16'h0004;
    localparam logic [OFF_W-1:0] REG_FIFO_OUT = 16'h0008;
    localparam logic [OFF_W-1:0] REG_CTR      = 16'h0010;
    localparam logic [OFF_W-1:0] REG_KEY      = 16'h0020;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        X_IDLE  = 3'd0,
        X_WADDR = 3'd1,
        X_WDATA = 3'd2,
        X_WRESP = 3'd3,
        X_RADDR = 3'd4,
        X_RDATA = 3'd5
    } xfer_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_OUT   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_req_t;

    function automatic logic [ADDR_W-1:0] reg_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [OFF_W-1:0]  off);
        return base + ADDR_W'(off);
    endfunction

    // Big-endian word select: word 0 is the most significant slice.
    function automatic logic [DATA_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                   input logic [CNT_W-1:0] idx);
        logic [DATA_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [BLK_W-1:0] blk_put(input logic [BLK_W-1:0]  blk,
                                                 input logic [CNT_W-1:0]  idx,
                                                 input logic [DATA_W-1:0] word);
        logic [BLK_W-1:0] b;
        b = blk;
        case (idx)
            2'd0:    b[127:96] = word;
            2'd1:    b[95:64]  = word;
            2'd2:    b[63:32]  = word;
            default: b[31:0]   = word;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/aes_block_initiator_xfer.sv
// Single AXI4-Lite transaction engine (one write or one read at a time).
// Optional AXIL_TIMEOUT_EN bounds every pending handshake to TIMEOUT_CYCLES.
module axil_single_xfer
    import aes_block_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  xfer_req_t         i_req,
    output logic              o_done_c,
    output logic [DATA_W-1:0] o_rdata_c,
    output logic              o_resp_err_c,
    output logic              o_timeout_c,
    output logic              o_wraddr_valid,
    input  logic              i_wraddr_ready,
    output logic [ADDR_W-1:0] o_wraddr,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [DATA_W-1:0] o_wr_dat,
    input  logic              i_wrresp_valid,
    output logic              o_wrresp_ready,
    input  logic [RESP_W-1:0] i_wrresp_dat,
    output logic              o_rdaddr_valid,
    input  logic              i_rdaddr_ready,
    output logic [ADDR_W-1:0] o_rdaddr,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [DATA_W-1:0] i_rd_dat,
    input  logic [RESP_W-1:0] i_rdresp_dat
);

    xfer_state_e       r_state, w_state_nxt, w_start_state;
    logic              w_hs, w_done, w_load, w_timeout;
    logic              r_wraddr_valid, r_wr_valid, r_wrresp_ready, r_rdaddr_valid, r_rd_ready;
    logic              w_wraddr_valid_nxt, w_wr_valid_nxt, w_wrresp_ready_nxt;
    logic              w_rdaddr_valid_nxt, w_rd_ready_nxt;
    logic [ADDR_W-1:0] r_wraddr, r_rdaddr;
    logic [DATA_W-1:0] r_wr_dat;

    // Handshake of whichever channel the current phase is waiting on
    always_comb begin
        w_hs = 1'b0;
        case (r_state)
            X_WADDR: w_hs = i_wraddr_ready;
            X_WDATA: w_hs = i_wr_ready;
            X_WRESP: w_hs = i_wrresp_valid;
            X_RADDR: w_hs = i_rdaddr_ready;
            X_RDATA: w_hs = i_rd_valid;
            default: w_hs = 1'b0;
        endcase
    end

    assign w_done        = w_hs && ((r_state == X_WRESP) || (r_state == X_RDATA));
    assign w_load        = i_start && ((r_state == X_IDLE) || w_done);
    assign w_start_state = i_req.write ? X_WADDR : X_RADDR;

`ifdef AXIL_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait;

    assign w_timeout = (r_state != X_IDLE) && !w_hs && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if ((r_state == X_IDLE) || w_hs || w_timeout) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= X_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new request is accepted in the same cycle the previous one completes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            X_IDLE:  if (i_start) w_state_nxt = w_start_state;
            X_WADDR: if (w_hs) w_state_nxt = X_WDATA;
            X_WDATA: if (w_hs) w_state_nxt = X_WRESP;
            X_WRESP: if (w_hs) w_state_nxt = i_start ? w_start_state : X_IDLE;
            X_RADDR: if (w_hs) w_state_nxt = X_RDATA;
            X_RDATA: if (w_hs) w_state_nxt = i_start ? w_start_state : X_IDLE;
            default: w_state_nxt = X_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = X_IDLE;
        end
    end

    always_comb begin
        w_wraddr_valid_nxt = (w_state_nxt == X_WADDR);
        w_wr_valid_nxt     = (w_state_nxt == X_WDATA);
        w_wrresp_ready_nxt = (w_state_nxt == X_WRESP);
        w_rdaddr_valid_nxt = (w_state_nxt == X_RADDR);
        w_rd_ready_nxt     = (w_state_nxt == X_RDATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wraddr_valid <= 1'b0;
            r_wr_valid     <= 1'b0;
            r_wrresp_ready <= 1'b0;
            r_rdaddr_valid <= 1'b0;
            r_rd_ready     <= 1'b0;
            r_wraddr       <= '0;
            r_wr_dat       <= '0;
            r_rdaddr       <= '0;
        end else begin
            r_wraddr_valid <= w_wraddr_valid_nxt;
            r_wr_valid     <= w_wr_valid_nxt;
            r_wrresp_ready <= w_wrresp_ready_nxt;
            r_rdaddr_valid <= w_rdaddr_valid_nxt;
            r_rd_ready     <= w_rd_ready_nxt;
            if (w_load && i_req.write) begin
                r_wraddr <= i_req.addr;
                r_wr_dat <= i_req.wdata;
            end
            if (w_load && !i_req.write) begin
                r_rdaddr <= i_req.addr;
            end
        end
    end

    assign o_done_c     = w_done;
    assign o_rdata_c    = i_rd_dat;
    assign o_resp_err_c = w_done && (((r_state == X_WRESP) && (i_wrresp_dat != RESP_OKAY)) ||
                                     ((r_state == X_RDATA) && (i_rdresp_dat != RESP_OKAY)));
    assign o_timeout_c  = w_timeout;

    assign o_wraddr_valid = r_wraddr_valid;
    assign o_wraddr       = r_wraddr;
    assign o_wr_valid     = r_wr_valid;
    assign o_wr_dat       = r_wr_dat;
    assign o_wrresp_ready = r_wrresp_ready;
    assign o_rdaddr_valid = r_rdaddr_valid;
    assign o_rdaddr       = r_rdaddr;
    assign o_rd_ready     = r_rd_ready;

endmodule

// File: rtl/aes_block_initiator.sv
// Streams 128-bit blocks through the AES accelerator's FIFO registers over AXI4-Lite.
// Optional AXIL_TIMEOUT_EN aborts a stuck handshake after TIMEOUT_CYCLES and flags err.
module aes_block_initiator
    import aes_block_initiator_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 38'h0,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    output logic              wraddr_valid,
    input  logic              wraddr_ready,
    output logic [ADDR_W-1:0] wraddr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_dat,
    input  logic              wrresp_valid,
    output logic              wrresp_ready,
    input  logic [RESP_W-1:0] wrresp_dat,
    output logic              rdaddr_valid,
    input  logic              rdaddr_ready,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [DATA_W-1:0] rd_dat,
    input  logic [RESP_W-1:0] rdresp_dat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_block,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] WR_ADDR   = reg_addr(BASE_ADDR, REG_FIFO_IN);
    localparam logic [ADDR_W-1:0] RD_ADDR   = reg_addr(BASE_ADDR, REG_FIFO_OUT);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(3);

    seq_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [BLK_W-1:0]  r_blk, r_out_block;
    logic              r_in_ready, r_out_valid, r_busy, r_err;
    logic              w_in_ready_nxt, w_out_valid_nxt, w_busy_nxt, w_err_nxt;
    logic              w_accept, w_start, w_done, w_resp_err, w_timeout;
    logic [DATA_W-1:0] w_rdata;
    xfer_req_t         w_req;

    assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Word sequencer: four writes, then four reads, then hand the result out
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_req.write = 1'b1;
        w_req.addr  = WR_ADDR;
        w_req.wdata = blk_word(r_blk, r_cnt + CNT_W'(1));
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WRITE;
                    w_cnt_nxt   = '0;
                    w_start     = 1'b1;
                    w_req.wdata = blk_word(in_block, CNT_W'(0));
                end
            end
            S_WRITE: begin
                if (w_done) begin
                    w_start = 1'b1;
                    if (r_cnt == LAST_WORD) begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = '0;
                        w_req.write = 1'b0;
                        w_req.addr  = RD_ADDR;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_READ: begin
                if (w_done) begin
                    if (r_cnt == LAST_WORD) begin
                        w_state_nxt = S_OUT;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_start     = 1'b1;
                        w_req.write = 1'b0;
                        w_req.addr  = RD_ADDR;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_start     = 1'b0;
        end
    end

    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_OUT);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_err_nxt       = r_err | w_resp_err | w_timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_blk       <= '0;
            r_out_block <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            if (w_accept) begin
                r_blk <= in_block;
            end
            if ((r_state == S_READ) && w_done) begin
                r_out_block <= blk_put(r_out_block, r_cnt, w_rdata);
            end
        end
    end

    axil_single_xfer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_xfer (
        .clk            (clk),
        .rst            (rst),
        .i_start        (w_start),
        .i_req          (w_req),
        .o_done_c       (w_done),
        .o_rdata_c      (w_rdata),
        .o_resp_err_c   (w_resp_err),
        .o_timeout_c    (w_timeout),
        .o_wraddr_valid (wraddr_valid),
        .i_wraddr_ready (wraddr_ready),
        .o_wraddr       (wraddr),
        .o_wr_valid     (wr_valid),
        .i_wr_ready     (wr_ready),
        .o_wr_dat       (wr_dat),
        .i_wrresp_valid (wrresp_valid),
        .o_wrresp_ready (wrresp_ready),
        .i_wrresp_dat   (wrresp_dat),
        .o_rdaddr_valid (rdaddr_valid),
        .i_rdaddr_ready (rdaddr_ready),
        .o_rdaddr       (rdaddr),
        .i_rd_valid     (rd_valid),
        .o_rd_ready     (rd_ready),
        .i_rd_dat       (rd_dat),
        .i_rdresp_dat   (rdresp_dat)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_aes_block_initiator.sv
// Self-checking bench for aes_block_initiator: table vectors, reset sequence, random slave.
module tb_aes_block_initiator;

    logic         clk;
    logic         rst;
    logic         wraddr_valid, wraddr_ready;
    logic [37:0]  wraddr;
    logic         wr_valid, wr_ready;
    logic [31:0]  wr_dat;
    logic         wrresp_valid, wrresp_ready;
    logic [1:0]   wrresp_dat;
    logic         rdaddr_valid, rdaddr_ready;
    logic [37:0]  rdaddr;
    logic         rd_valid, rd_ready;
    logic [31:0]  rd_dat;
    logic [1:0]   rdresp_dat;
    logic         in_valid, in_ready;
    logic [127:0] in_block;
    logic         out_valid, out_ready;
    logic [127:0] out_block;
    logic         busy, err;

    aes_block_initiator #(
        .BASE_ADDR      (38'h0),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wraddr_valid (wraddr_valid),
        .wraddr_ready (wraddr_ready),
        .wraddr       (wraddr),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_dat       (wr_dat),
        .wrresp_valid (wrresp_valid),
        .wrresp_ready (wrresp_ready),
        .wrresp_dat   (wrresp_dat),
        .rdaddr_valid (rdaddr_valid),
        .rdaddr_ready (rdaddr_ready),
        .rdaddr       (rdaddr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_dat       (rd_dat),
        .rdresp_dat   (rdresp_dat),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_block     (in_block),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_block    (out_block),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] blk;
        int           rnd;
        int           wstall2;
        int           err_rd;
        int           out_hold;
        int           exp_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int k);
        return 32'(b >> (96 - 32 * k));
    endfunction

    // One block end to end; the slave behaviour and expected results come from v
    task automatic run_block(input vec_t v);
        logic [31:0]  rdw [4];
        logic [127:0] exp_out, p_ob;
        logic [37:0]  p_waddr, p_raddr;
        logic [31:0]  p_wdat;
        logic         p_wa, p_wd, p_ra, p_ov;
        bit           hwa, hwd, hwr, hra, hrd, hout, done;
        int           nwa, nwd, nwr, nra, nrd, lat, hold, stall, viol;
        for (int k = 0; k < 4; k++) rdw[k] = $urandom;
        exp_out = {rdw[0], rdw[1], rdw[2], rdw[3]};
        nwa = 0; nwd = 0; nwr = 0; nra = 0; nrd = 0;
        lat = -1; hold = v.out_hold; stall = v.wstall2; viol = 0; done = 1'b0;
        p_wa = 1'b0; p_wd = 1'b0; p_ra = 1'b0; p_ov = 1'b0;
        p_waddr = '0; p_raddr = '0; p_wdat = '0; p_ob = '0;

        chk("in_ready_before_accept", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_block = v.blk;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_block = {$urandom, $urandom, $urandom, $urandom};

        for (int n = 0; n < 3000 && !done; n++) begin
            if (p_wa && !(wraddr_valid && wraddr == p_waddr)) viol++;
            if (p_wd && !(wr_valid && wr_dat == p_wdat)) viol++;
            if (p_ra && !(rdaddr_valid && rdaddr == p_raddr)) viol++;
            if (p_ov && !(out_valid && out_block == p_ob)) viol++;
            if ($countones({wraddr_valid, wr_valid, wrresp_ready, rdaddr_valid,
                            rd_ready, out_valid, in_ready}) > 1) viol++;
            if (!busy) viol++;
            if (out_valid && lat < 0) lat = n + 1;

            if (v.rnd != 0) begin
                wraddr_ready = ($urandom_range(0, 3) != 0);
                wr_ready     = ($urandom_range(0, 3) != 0);
                wrresp_valid = ($urandom_range(0, 3) != 0);
                rdaddr_ready = ($urandom_range(0, 3) != 0);
                rd_valid     = ($urandom_range(0, 3) != 0);
            end else begin
                wraddr_ready = 1'b1;
                wr_ready     = 1'b1;
                wrresp_valid = 1'b1;
                rdaddr_ready = 1'b1;
                rd_valid     = 1'b1;
            end
            if (wr_valid && nwd == 2 && stall > 0) begin
                wr_ready = 1'b0;
                stall--;
            end
            wrresp_dat = (v.rnd != 0 && $urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            rd_dat     = rdw[nrd & 3];
            rdresp_dat = (nrd == v.err_rd ||
                          (v.rnd != 0 && $urandom_range(0, 15) == 0)) ? 2'b10 : 2'b00;
            if (out_valid) begin
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            hwa  = wraddr_valid && wraddr_ready;
            hwd  = wr_valid && wr_ready;
            hwr  = wrresp_valid && wrresp_ready;
            hra  = rdaddr_valid && rdaddr_ready;
            hrd  = rd_valid && rd_ready;
            hout = out_valid && out_ready;
            if (hwa) begin
                chk($sformatf("write_addr%0d", nwa), 128'(wraddr), 128'(38'h4));
                if (nwa != nwd || nwd != nwr) viol++;
                nwa++;
            end
            if (hwd) begin
                chk($sformatf("write_data%0d", nwd), 128'(wr_dat), 128'(word_of(v.blk, nwd)));
                if (nwd + 1 != nwa) viol++;
                nwd++;
            end
            if (hwr) begin
                if (wrresp_dat != 2'b00) exp_err = 1'b1;
                if (nwr + 1 != nwd) viol++;
                nwr++;
            end
            if (hra) begin
                chk($sformatf("read_addr%0d", nra), 128'(rdaddr), 128'(38'h8));
                if (nwr != 4 || nra != nrd) viol++;
                nra++;
            end
            if (hrd) begin
                if (rdresp_dat != 2'b00) exp_err = 1'b1;
                if (nrd + 1 != nra) viol++;
                nrd++;
            end
            if (hout) begin
                chk("out_block", out_block, exp_out);
                chk("err_at_out", 128'(err), 128'(exp_err));
                done = 1'b1;
            end

            p_wa = wraddr_valid && !hwa; p_waddr = wraddr;
            p_wd = wr_valid && !hwd;     p_wdat  = wr_dat;
            p_ra = rdaddr_valid && !hra; p_raddr = rdaddr;
            p_ov = out_valid && !hout;   p_ob    = out_block;
            @(posedge clk);
            @(negedge clk);
        end

        chk("block_done", 128'(done), 128'(1));
        if (v.exp_lat >= 0) chk("latency", 128'(lat), 128'(v.exp_lat));
        chk("xfer_counts", {88'(0), 8'(nwa), 8'(nwd), 8'(nwr), 8'(nra), 8'(nrd)},
            {88'(0), 8'd4, 8'd4, 8'd4, 8'd4, 8'd4});
        chk("protocol_violations", 128'(viol), 128'(0));
        chk("idle_after_out", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        out_ready = 1'b0;
    endtask

    vec_t vecs [5];
    vec_t rv;

    initial begin
        vecs[0] = '{blk: 128'h00112233_44556677_8899aabb_ccddeeff, rnd: 0, wstall2: 0,
                    err_rd: -1, out_hold: 0,  exp_lat: 21};
        vecs[1] = '{blk: 128'h00112233_44556677_8899aabb_ccddeeff, rnd: 0, wstall2: 5,
                    err_rd: -1, out_hold: 0,  exp_lat: 26};
        vecs[2] = '{blk: 128'hdeadbeef_01234567_89abcdef_fedcba98, rnd: 0, wstall2: 0,
                    err_rd: 3,  out_hold: 0,  exp_lat: 21};
        vecs[3] = '{blk: 128'h0f0f0f0f_f0f0f0f0_55555555_aaaaaaaa, rnd: 0, wstall2: 0,
                    err_rd: -1, out_hold: 0,  exp_lat: 21};
        vecs[4] = '{blk: 128'hcafef00d_12345678_9abcdef0_13579bdf, rnd: 0, wstall2: 0,
                    err_rd: -1, out_hold: 10, exp_lat: 21};

        rst = 1'b0;
        in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        wraddr_ready = 1'b0; wr_ready = 1'b0; wrresp_valid = 1'b0; wrresp_dat = 2'b00;
        rdaddr_ready = 1'b0; rd_valid = 1'b0; rd_dat = '0; rdresp_dat = 2'b00;
        repeat (3) @(negedge clk);

        chk("reset_handshakes", 128'({wraddr_valid, wr_valid, wrresp_ready, rdaddr_valid,
                                       rd_ready, out_valid, in_ready}), 128'(0));
        chk("reset_busy_err", 128'({busy, err}), 128'(0));
        chk("reset_addr_data", 128'({wraddr, rdaddr, wr_dat}), 128'(0));
        chk("reset_out_block", out_block, 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 128'(in_ready), 128'(1));
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i]);
            chk($sformatf("sticky_err_vec%0d", i), 128'(err), 128'(exp_err));
        end

        // Asynchronous reset in the middle of a block
        wraddr_ready = 1'b1; wr_ready = 1'b1; wrresp_valid = 1'b1;
        rdaddr_ready = 1'b1; rd_valid = 1'b1; wrresp_dat = 2'b00; rdresp_dat = 2'b00;
        in_valid = 1'b1;
        in_block = 128'h11111111_22222222_33333333_44444444;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("busy_before_midreset", 128'(busy), 128'(1));
        #2 rst = 1'b0;
        #1;
        chk("midreset_handshakes", 128'({wraddr_valid, wr_valid, wrresp_ready, rdaddr_valid,
                                          rd_ready, out_valid, in_ready}), 128'(0));
        chk("midreset_busy_err", 128'({busy, err}), 128'({1'b0, 1'b0}));
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_midreset", 128'(in_ready), 128'(1));
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rv.blk      = {$urandom, $urandom, $urandom, $urandom};
            rv.rnd      = 1;
            rv.wstall2  = int'($urandom_range(0, 3));
            rv.err_rd   = int'($urandom_range(0, 7)) - 4;
            rv.out_hold = int'($urandom_range(0, 3));
            rv.exp_lat  = -1;
            run_block(rv);
        end
        chk("final_err", 128'(err), 128'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
